// File: rtl/data_sram_responder.sv
// data_sram_responder: fixed-latency data RAM responder with stall; define ADDR_CHECK_EN to build access-error checking
module data_sram_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        data_ok,
   output logic        stall,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d, wen_q, wen_d, a_wen;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, a_addr, a_wdata;
   logic data_ok_q, data_ok_d, err_q, err_d, accept, go, bad;
   logic [ADDR_W-1:0] idx;
   logic [31:0] mem [2**ADDR_W];
   assign accept = en && state_q != WAIT;
   assign go = (state_q == WAIT) ? cnt_q == 4'd0 : accept && WAIT_CYCLES == 0;
   assign a_wen = (state_q == WAIT) ? wen_q : wen;
   assign a_addr = (state_q == WAIT) ? addr_q : addr;
   assign a_wdata = (state_q == WAIT) ? wdata_q : wdata;
   assign idx = a_addr[ADDR_W+1:2];
   assign stall = state_q == WAIT || (accept && WAIT_CYCLES != 0);
   assign rdata = rdata_q;
   assign data_ok = data_ok_q;
   assign err = err_q;
`ifdef ADDR_CHECK_EN
   assign bad = (a_addr >> (ADDR_W + 2)) != 32'd0 ||
                (a_wen == 4'b1111 && a_addr[1:0] != 2'b00) ||
                ((a_wen == 4'b0011 || a_wen == 4'b1100) && a_addr[0]);
`else
   logic unused_ok;
   assign unused_ok = ^{a_addr[31:ADDR_W+2], a_addr[1:0]};
   assign bad = 1'b0;
`endif
   // next state: accept into WAIT or RESP, count down waits, capture read data on entry to RESP
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      wen_d = wen_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      data_ok_d = go;
      err_d = go && bad;
      rdata_d = go ? (bad ? 32'd0 : mem[idx]) : rdata_q;
      if (accept) begin
         wen_d = wen;
         addr_d = addr;
         wdata_d = wdata;
         state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
         cnt_d = 4'(WAIT_CYCLES - 1);
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
         state_d = cnt_q == 4'd0 ? RESP : WAIT;
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end
   end
   // state and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= 4'd0;
         wen_q <= 4'd0;
         addr_q <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         data_ok_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         wen_q <= wen_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         data_ok_q <= data_ok_d;
         err_q <= err_d;
      end
   end
   // byte-lane write commits on the edge that enters RESP, after the old word is captured
   always_ff @(posedge clk) begin
      if (!rst && go && !bad)
         for (int i = 0; i < 4; i++)
            if (a_wen[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: randomized and directed checks of two responders (0 and 3 wait cycles) against a word-array model
module tb_data_sram_responder;
   localparam int ADDR_W = 10;
   localparam int DEPTH = 2**ADDR_W;
   logic clk = 1'b0;
   logic rst0, rst3, en0, en3;
   logic [3:0] wen0, wen3;
   logic [31:0] addr0, addr3, wdata0, wdata3, rdata0, rdata3;
   logic data_ok0, data_ok3, stall0, stall3, err0, err3;
   int checks = 0, errors = 0;
   logic [31:0] ref_mem [int];
   logic [3:0] wl [8];
   always #5 clk = ~clk;
   data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst0), .en(en0), .wen(wen0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .data_ok(data_ok0), .stall(stall0), .err(err0));
   data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst3), .en(en3), .wen(wen3), .addr(addr3), .wdata(wdata3),
      .rdata(rdata3), .data_ok(data_ok3), .stall(stall3), .err(err3));

   function automatic void ref_access(input int inst, input logic [3:0] w, input logic [31:0] a, d,
                                      output logic [31:0] rd, output logic er, output logic known);
      int k;
      logic [31:0] old;
      k = inst * DEPTH + int'((a / 4) % DEPTH);
      er = 1'b0;
`ifdef ADDR_CHECK_EN
      er = a >= 32'(4 * DEPTH) || (w == 4'b1111 && a % 4 != 0) || ((w == 4'b0011 || w == 4'b1100) && a % 2 != 0);
`endif
      known = er || ref_mem.exists(k);
      old = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      rd = er ? 32'h0 : old;
      if (!er && w != 4'b0000) begin
         for (int i = 0; i < 4; i++) if (w[i]) old[8*i +: 8] = d[8*i +: 8];
         ref_mem[k] = old;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic acc0(input logic [3:0] w, input logic [31:0] a, d, output logic st, ok, output logic [31:0] rd, output logic er);
      en0 = 1'b1; wen0 = w; addr0 = a; wdata0 = d;
      #1 st = stall0;
      tick();
      ok = data_ok0; rd = rdata0; er = err0;
      en0 = 1'b0;
   endtask

   task automatic acc3(input logic [3:0] w, input logic [31:0] a, d, output int nst, lat, nok, output logic [31:0] rd, output logic er);
      en3 = 1'b1; wen3 = w; addr3 = a; wdata3 = d;
      #1 nst = int'(stall3);
      lat = 0; nok = 0; rd = 32'h0; er = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         nst += int'(stall3);
         if (data_ok3) begin
            nok++;
            if (lat == 0) begin lat = i; rd = rdata3; er = err3; end
         end
         if (i == 3) en3 = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst3 = 1'b1; en0 = 1'b0; en3 = 1'b0;
      wen0 = 4'h0; wen3 = 4'h0; addr0 = 32'h0; addr3 = 32'h0; wdata0 = 32'h0; wdata3 = 32'h0;
      repeat (3) tick();
      checks += 6;
      if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
      if (data_ok0 !== 1'b0) begin errors++; $display("FAIL reset_data_ok0 got %b exp 0", data_ok0); end
      if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b exp 0", err0); end
      if (rdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got %h exp 0", rdata3); end
      if (data_ok3 !== 1'b0) begin errors++; $display("FAIL reset_data_ok3 got %b exp 0", data_ok3); end
      if (stall3 !== 1'b0) begin errors++; $display("FAIL reset_stall3 got %b exp 0", stall3); end
      rst0 = 1'b0; rst3 = 1'b0;
   endtask

   task automatic test_full_word();
      logic st, ok, er, xer, kn;
      logic [31:0] rd, xrd;
      acc0(4'hF, 32'h10, 32'hDEADBEEF, st, ok, rd, er);
      ref_access(0, 4'hF, 32'h10, 32'hDEADBEEF, xrd, xer, kn);
      checks += 2;
      if (ok !== 1'b1) begin errors++; $display("FAIL fw_write_ok got %b exp 1", ok); end
      if (st !== 1'b0) begin errors++; $display("FAIL fw_write_stall got %b exp 0", st); end
      acc0(4'h0, 32'h10, 32'h0, st, ok, rd, er);
      ref_access(0, 4'h0, 32'h10, 32'h0, xrd, xer, kn);
      checks += 3;
      if (ok !== 1'b1) begin errors++; $display("FAIL fw_read_ok got %b exp 1", ok); end
      if (st !== 1'b0) begin errors++; $display("FAIL fw_read_stall got %b exp 0", st); end
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_read_data got %h exp deadbeef", rd); end
   endtask

   task automatic test_lanes();
      logic st, ok, er, xer, kn;
      logic [31:0] rd, xrd;
      acc0(4'b1111, 32'h20, 32'h11223344, st, ok, rd, er);
      ref_access(0, 4'b1111, 32'h20, 32'h11223344, xrd, xer, kn);
      acc0(4'b0100, 32'h20, 32'hAAAAAAAA, st, ok, rd, er);
      ref_access(0, 4'b0100, 32'h20, 32'hAAAAAAAA, xrd, xer, kn);
      checks++;
      if (rd !== xrd) begin errors++; $display("FAIL lanes_old got %h exp %h", rd, xrd); end
      acc0(4'b0011, 32'h20, 32'h55665566, st, ok, rd, er);
      ref_access(0, 4'b0011, 32'h20, 32'h55665566, xrd, xer, kn);
      acc0(4'b0000, 32'h20, 32'h0, st, ok, rd, er);
      ref_access(0, 4'b0000, 32'h20, 32'h0, xrd, xer, kn);
      checks += 2;
      if (rd !== 32'h11AA5566) begin errors++; $display("FAIL lanes_read got %h exp 11aa5566", rd); end
      if (ok !== 1'b1) begin errors++; $display("FAIL lanes_ok got %b exp 1", ok); end
   endtask

   task automatic test_back_to_back();
      logic st, ok, er, xer, kn;
      logic [31:0] rd, xrd;
      acc0(4'hF, 32'h30, 32'h0000CAFE, st, ok, rd, er);
      ref_access(0, 4'hF, 32'h30, 32'h0000CAFE, xrd, xer, kn);
      acc0(4'h0, 32'h30, 32'h0, st, ok, rd, er);
      ref_access(0, 4'h0, 32'h30, 32'h0, xrd, xer, kn);
      checks += 2;
      if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ok got %b exp 1", ok); end
      if (rd !== 32'h0000CAFE) begin errors++; $display("FAIL b2b_data got %h exp 0000cafe", rd); end
      tick();
      checks += 2;
      if (data_ok0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_ok got %b exp 0", data_ok0); end
      if (rdata0 !== 32'h0000CAFE) begin errors++; $display("FAIL b2b_hold got %h exp 0000cafe", rdata0); end
   endtask

   task automatic test_random_b2b();
      logic st, ok, er, xer, kn;
      logic [31:0] rd, xrd, a, d, last;
      logic [3:0] w;
      for (int k = 0; k < 8; k++) begin
         d = $urandom;
         acc0(4'hF, 32'(k * 4), d, st, ok, rd, er);
         ref_access(0, 4'hF, 32'(k * 4), d, xrd, xer, kn);
      end
      last = 32'h0;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            w = wl[$urandom_range(0, 7)];
            a = 32'($urandom_range(0, 7) * 4);
            d = $urandom;
            acc0(w, a, d, st, ok, rd, er);
            ref_access(0, w, a, d, xrd, xer, kn);
            last = xrd;
            checks += 4;
            if (ok !== 1'b1) begin errors++; $display("FAIL rnd_ok n=%0d got %b exp 1", n, ok); end
            if (st !== 1'b0) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp 0", n, st); end
            if (er !== xer) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, er, xer); end
            if (kn && rd !== xrd) begin errors++; $display("FAIL rnd_data n=%0d addr=%h got %h exp %h", n, a, rd, xrd); end
         end else begin
            en0 = 1'b0;
            tick();
            checks += 2;
            if (data_ok0 !== 1'b0) begin errors++; $display("FAIL rnd_idle_ok n=%0d got %b exp 0", n, data_ok0); end
            if (rdata0 !== last) begin errors++; $display("FAIL rnd_hold n=%0d got %h exp %h", n, rdata0, last); end
         end
      end
   endtask

   task automatic test_wait();
      int nst, lat, nok;
      logic er, xer, kn;
      logic [31:0] rd, xrd, a, d;
      logic [3:0] w;
      for (int k = 0; k < 8; k++) begin
         d = $urandom;
         acc3(4'hF, 32'(k * 4), d, nst, lat, nok, rd, er);
         ref_access(1, 4'hF, 32'(k * 4), d, xrd, xer, kn);
      end
      acc3(4'h0, 32'h10, 32'h0, nst, lat, nok, rd, er);
      ref_access(1, 4'h0, 32'h10, 32'h0, xrd, xer, kn);
      checks += 4;
      if (nst !== 4) begin errors++; $display("FAIL wait_stall_cycles got %0d exp 4", nst); end
      if (lat !== 4) begin errors++; $display("FAIL wait_latency got %0d exp 4", lat); end
      if (nok !== 1) begin errors++; $display("FAIL wait_responses got %0d exp 1", nok); end
      if (rd !== xrd) begin errors++; $display("FAIL wait_data got %h exp %h", rd, xrd); end
      for (int n = 0; n < 12; n++) begin
         w = wl[$urandom_range(0, 7)];
         a = 32'($urandom_range(0, 7) * 4);
         d = $urandom;
         acc3(w, a, d, nst, lat, nok, rd, er);
         ref_access(1, w, a, d, xrd, xer, kn);
         checks += 4;
         if (nst !== 4) begin errors++; $display("FAIL wrnd_stall n=%0d got %0d exp 4", n, nst); end
         if (lat !== 4) begin errors++; $display("FAIL wrnd_latency n=%0d got %0d exp 4", n, lat); end
         if (nok !== 1) begin errors++; $display("FAIL wrnd_responses n=%0d got %0d exp 1", n, nok); end
         if (kn && rd !== xrd) begin errors++; $display("FAIL wrnd_data n=%0d got %h exp %h", n, rd, xrd); end
      end
   endtask

   task automatic test_reset_mid();
      int nst, lat, nok, okseen;
      logic er, xer, kn;
      logic [31:0] rd, xrd;
      acc3(4'hF, 32'h40, 32'h0BADF00D, nst, lat, nok, rd, er);
      ref_access(1, 4'hF, 32'h40, 32'h0BADF00D, xrd, xer, kn);
      en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h40; wdata3 = 32'h12345678;
      tick();
      en3 = 1'b0; rst3 = 1'b1;
      tick();
      checks += 3;
      if (data_ok3 !== 1'b0) begin errors++; $display("FAIL rstmid_ok got %b exp 0", data_ok3); end
      if (stall3 !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall3); end
      if (rdata3 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", rdata3); end
      rst3 = 1'b0;
      tick();
      acc3(4'h0, 32'h40, 32'h0, nst, lat, nok, rd, er);
      ref_access(1, 4'h0, 32'h40, 32'h0, xrd, xer, kn);
      checks++;
      if (rd !== xrd) begin errors++; $display("FAIL rstmid_prior got %h exp %h", rd, xrd); end
      rst3 = 1'b1; en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h40; wdata3 = 32'hFFFF0000;
      tick();
      rst3 = 1'b0; en3 = 1'b0;
      okseen = 0;
      repeat (6) begin tick(); okseen += int'(data_ok3); end
      checks++;
      if (okseen !== 0) begin errors++; $display("FAIL rsten_dropped got %0d responses exp 0", okseen); end
      acc3(4'h0, 32'h40, 32'h0, nst, lat, nok, rd, er);
      ref_access(1, 4'h0, 32'h40, 32'h0, xrd, xer, kn);
      checks++;
      if (rd !== xrd) begin errors++; $display("FAIL rsten_prior got %h exp %h", rd, xrd); end
   endtask

   task automatic test_addr_check();
      logic st, ok, er, xer, kn;
      logic [31:0] rd, xrd;
      logic [3:0] ws [5];
      logic [31:0] as [5];
      ws = '{4'hF, 4'hF, 4'hF, 4'b1100, 4'b0011};
      as = '{32'h0, 32'h40, 32'h41, 32'h00010000, 32'h43};
      for (int k = 0; k < 2; k++) begin
         acc0(ws[k], as[k], 32'hA0A0A0A0 + 32'(k), st, ok, rd, er);
         ref_access(0, ws[k], as[k], 32'hA0A0A0A0 + 32'(k), xrd, xer, kn);
      end
      for (int k = 2; k < 5; k++) begin
         acc0(ws[k], as[k], 32'hBEEF0000 + 32'(k), st, ok, rd, er);
         ref_access(0, ws[k], as[k], 32'hBEEF0000 + 32'(k), xrd, xer, kn);
         checks += 3;
         if (ok !== 1'b1) begin errors++; $display("FAIL achk_ok k=%0d got %b exp 1", k, ok); end
         if (er !== xer) begin errors++; $display("FAIL achk_err k=%0d got %b exp %b", k, er, xer); end
         if (kn && rd !== xrd) begin errors++; $display("FAIL achk_data k=%0d got %h exp %h", k, rd, xrd); end
      end
      for (int k = 0; k < 2; k++) begin
         acc0(4'h0, as[k], 32'h0, st, ok, rd, er);
         ref_access(0, 4'h0, as[k], 32'h0, xrd, xer, kn);
         checks++;
         if (rd !== xrd) begin errors++; $display("FAIL achk_mem k=%0d got %h exp %h", k, rd, xrd); end
      end
   endtask

   initial begin
      wl = '{4'h0, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};
      test_reset();
      test_full_word();
      test_lanes();
      test_back_to_back();
      test_random_b2b();
      test_wait();
      test_reset_mid();
      test_addr_check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
